spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//  SPI secondary (responder) for the controller side of our SPI link.
//  - Mode 0 (CPOL=0, CPHA=0), MSB first.
//  - Oversamples sclk/csb/mosi in the local clk domain.
//  - Receives full-duplex words on mosi and hands them out on an o_valid/o_ready port.
//  - Shifts words supplied on the i_valid/i_ready port out on miso.
//  - Used as a loopback/peripheral model on FPGA and in controller testbenches.
// PARAMETERS
//  WORD_BITS    8  bits per SPI word; frames are any number of whole words
//  SYNC_STAGES  2  flops in each input synchronizer (>=2)
// PORTS
//  clk          in   1          local clock; sclk high and low phases each >= SYNC_STAGES+2 clk periods
//  rst          in   1          reset, asynchronous, active-high
//  sclk         in   1          serial clock from controller (async to clk)
//  csb          in   1          chip select bar from controller (async to clk)
//  mosi         in   1          serial data from controller (async to clk)
//  miso         out  1          serial data to controller
//  i_ready      out  1          tx holding register empty
//  i_valid      in   1          tx word offered
//  i_data       in   WORD_BITS  tx word (next word to shift out)
//  o_ready      in   1          consumer accepts o_data
//  o_valid      out  1          received word available
//  o_data       out  WORD_BITS  received word
//  frame_done   out  1          one-cycle pulse on synchronized csb rising
//  underrun     out  1          sticky: word boundary reached with holding register empty
//  overrun      out  1          sticky: word completed while o_valid && !o_ready
//  mode_err     out  1          sticky: synchronized sclk==1 at csb falling edge
//  bit_counter  out  $clog2(WORD_BITS+1)  bits received in the current word
// BEHAVIOUR
//  Reset (async): state=S_IDLE; miso=0, i_ready=1, o_valid=0, o_data=0, frame_done=0;
//    underrun=0, overrun=0, mode_err=0, bit_counter=0; shift and holding regs=0.
//  Edge detection
//  - Synchronizer output history is cleared on reset.
//  - csb_fall/csb_rise/sclk_rise/sclk_fall are single-cycle strobes from synchronized signals.
//  - Use the synchronized mosi value on the cycle of sclk_rise.
//  TX holding register (one entry)
//  - i_valid && i_ready: capture i_data; i_ready<=0.
//  - Emptied (i_ready<=1) when its word is moved to the tx shifter.
//  FSM states
//  - S_IDLE:
//    - csb_fall -> S_SHIFT; bit_counter<=0.
//    - Load tx shifter from holding reg, or 0 with underrun<=1 if empty.
//    - mode_err<=1 if synchronized sclk==1.
//  - S_SHIFT, on sclk_rise:
//    - rx_shift<={rx_shift[WORD_BITS-2:0],mosi}; bit_counter++.
//    - When bit_counter reaches WORD_BITS:
//      - Next cycle: o_data<=word, o_valid<=1, bit_counter<=0.
//      - If o_valid && !o_ready at that point, set overrun and overwrite o_data.
//  - S_SHIFT, on sclk_fall:
//    - If bit_counter==0 (word boundary, not the first word): reload tx shifter from holding reg (or 0 + underrun).
//    - Otherwise shift tx left by 1.
//  - S_SHIFT, on csb_rise (priority over sclk strobes same cycle):
//    - Discard partial word; bit_counter<=0; -> S_DONE.
//  - S_DONE: frame_done=1 for exactly one cycle -> S_IDLE.
//  miso
//  - = tx_shift[WORD_BITS-1] while state==S_SHIFT, else 0.
//  - Valid before the first sclk_rise.
//  o_valid/o_ready
//  - o_valid holds until o_ready.
//  - o_ready only clears o_valid; it never stalls the SPI side.
//  Simultaneous events
//  - Word completion and o_ready in the same cycle: the old word is accepted, the new word is presented, no overrun.
//  - Sticky flags clear only on rst.
//  - sclk edges while csb is high are ignored.
// STRUCTURE
//  - Add to spi_types.sv:
//    - spi_periph_state_t {S_IDLE, S_SHIFT, S_DONE}
//    - localparam SPI_WORD_BITS_DEFAULT=8
//  - Sub-module spi_sync_edge (SYNC_STAGES synchronizer + rise/fall strobes).
//    Instantiate 3x: sclk, csb, mosi (mosi strobes unused).
//  - Top holds the FSM, shifters, holding reg and output port.
// TESTING
//  1. Assert rst mid-clock with no clk edge -> all outputs at reset values immediately; i_ready=1.
//  2. Preload i_data=8'h3C, controller sends 8'hA5 ->
//     miso bits 0,0,1,1,1,1,0,0; o_data=8'hA5 o_valid=1; frame_done pulse; underrun=0.
//  3. No preload, o_ready=1, 3-word frame 12,34,56 ->
//     o_valid pulses 3x with 8'h12,8'h34,8'h56; miso all 0; underrun=1.
//  4. o_ready=0, 2-word frame AA,55 -> overrun=1, o_data=8'h55, o_valid=1.
//  5. csb rises after 5 sclk rises -> no o_valid, frame_done pulse, bit_counter=0, miso=0.
//  6. Async rst pulsed mid-word, then a fresh frame 8'hC3 ->
//     o_data=8'hC3, no stale bits; csb_fall with sclk=1 sets mode_err=1.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared types and defaults for the SPI peripheral.
package spi_peripheral_pkg;

    localparam int SPI_WORD_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } spi_periph_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall strobes derived from the synchronized level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder, MSB first, oversampled in the clk domain.
// Received words go out on o_valid/o_ready; words to send arrive through a
// one-entry holding register on i_valid/i_ready.
//
// Handshakes: a transfer happens on a clk edge where valid && ready are both
// high; valid never waits for ready, and o_ready never stalls the SPI side.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int WORD_BITS   = SPI_WORD_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sclk,
    input  logic                             csb,
    input  logic                             mosi,
    output logic                             miso,
    output logic                             i_ready,
    input  logic                             i_valid,
    input  logic [WORD_BITS-1:0]             i_data,
    input  logic                             o_ready,
    output logic                             o_valid,
    output logic [WORD_BITS-1:0]             o_data,
    output logic                             frame_done,
    output logic                             underrun,
    output logic                             overrun,
    output logic                             mode_err,
    output logic [$clog2(WORD_BITS+1)-1:0]   bit_counter
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);

    spi_periph_state_t state, state_next;

    logic sclk_s, sclk_rise, sclk_fall;
    logic csb_s, csb_rise, csb_fall;
    logic mosi_s;
    logic [1:0] mosi_edges_unused;

    logic [WORD_BITS-1:0] rx_shift;
    logic [WORD_BITS-1:0] tx_shift;
    logic [WORD_BITS-1:0] hold_data;
    logic                 tx_empty;   // current tx word was loaded as filler zeros

    logic start, abort, rx_en, load_tx, shift_tx, word_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_in(sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csb (
        .clk(clk), .rst(rst), .async_in(csb),
        .level(csb_s), .rise(csb_rise), .fall(csb_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(mosi),
        .level(mosi_s), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    // A word is complete the cycle after its last bit was sampled.
    assign word_done = (state == S_SHIFT) && (bit_counter == CNT_W'(WORD_BITS));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle datapath controls; csb_rise beats sclk strobes.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        rx_en      = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (csb_fall) begin
                    state_next = S_SHIFT;
                    start      = 1'b1;
                    load_tx    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (csb_rise) begin
                    state_next = S_DONE;
                    abort      = 1'b1;
                end else begin
                    rx_en = sclk_rise;
                    if (sclk_fall) begin
                        if (bit_counter == '0) load_tx  = 1'b1;
                        else                   shift_tx = 1'b1;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bit counter and receive shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_counter <= '0;
            rx_shift    <= '0;
        end else begin
            if (start || abort || word_done) bit_counter <= '0;
            else if (rx_en)                  bit_counter <= bit_counter + CNT_W'(1);
            if (rx_en) rx_shift <= {rx_shift[WORD_BITS-2:0], mosi_s};
        end
    end

    // Transmit shifter and holding register. Filler zeros are loaded at every
    // word boundary when nothing is held; underrun is only flagged once the
    // controller actually clocks such a word, so the trailing sclk fall at the
    // end of a frame does not raise a false underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift  <= '0;
            tx_empty  <= 1'b0;
            hold_data <= '0;
            i_ready   <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            if (load_tx) begin
                if (!i_ready) begin
                    tx_shift <= hold_data;
                    tx_empty <= 1'b0;
                    i_ready  <= 1'b1;
                end else begin
                    tx_shift <= '0;
                    tx_empty <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
            end
            if (i_valid && i_ready) begin
                hold_data <= i_data;
                i_ready   <= 1'b0;
            end
            if (rx_en && bit_counter == '0 && tx_empty) underrun <= 1'b1;
        end
    end

    // Receive output port, overrun and mode error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            overrun  <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            if (word_done) begin
                o_data  <= rx_shift;
                o_valid <= 1'b1;
                if (o_valid && !o_ready) overrun <= 1'b1;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
            if (start && sclk_s) mode_err <= 1'b1;
        end
    end

    assign frame_done = (state == S_DONE);
    assign miso       = (state == S_SHIFT) ? tx_shift[WORD_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: table-driven single-word frames, hand-written
// multi-cycle sequences and randomized frames against a word-level model.
module tb_spi_peripheral;

    localparam int W    = 8;
    localparam int HALF = 6;   // sclk half period in clk cycles

    logic         clk = 0;
    logic         rst;
    logic         sclk, csb, mosi;
    logic         miso;
    logic         i_ready;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_data  = '0;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         frame_done, underrun, overrun, mode_err;
    logic [3:0]   bit_counter;

    spi_peripheral #(.WORD_BITS(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso),
        .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .frame_done(frame_done), .underrun(underrun), .overrun(overrun),
        .mode_err(mode_err), .bit_counter(bit_counter)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int ov_cnt   = 0;
    logic ov_prev = 1'b0;
    logic mon_en  = 1'b0;

    logic [W-1:0] exp_q[$];   // words the consumer should see, in order
    logic [W-1:0] tx_q[$];    // words to push into the holding register
    logic [W-1:0] fr_mosi[8];
    logic [W-1:0] fr_miso[8];
    logic [W-1:0] fr_txw[8];

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_odata;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holding-register driver: one word per i_ready window.
    always @(negedge clk) begin
        if (i_valid) i_valid = 1'b0;
        else if (tx_q.size() > 0 && i_ready && !rst) begin
            i_data  = tx_q.pop_front();
            i_valid = 1'b1;
        end
    end

    // Output monitor: scoreboard for accepted words plus event counters.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (o_valid && !ov_prev) ov_cnt++;
        ov_prev = o_valid;
        if (mon_en && o_valid && o_ready) begin
            if (exp_q.size() == 0) check("rx_unexpected_word", {24'h0, o_data}, 32'hFFFF_FFFF);
            else check("rx_word", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
        end
    end

    // Controller driver: nbits MSB-first bits; miso sampled just before each rise.
    task automatic spi_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[W-1-i];
            wait_clk(HALF);
            mi[W-1-i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        csb = 1'b0;
        wait_clk(8);
        for (int k = 0; k < n; k++) spi_bits(fr_mosi[k], W, fr_miso[k]);
        wait_clk(8);
        csb = 1'b1;
        wait_clk(10);
    endtask

    task automatic preload(input logic [W-1:0] d);
        int t;
        tx_q.push_back(d);
        t = 0;
        while (i_ready && t < 20) begin
            wait_clk(1);
            t++;
        end
        check("preload_taken", {31'h0, i_ready}, 32'h0);
        wait_clk(1);
    endtask

    task automatic drain();
        o_ready = 1'b1;
        wait_clk(2);
        o_ready = 1'b0;
        check("drain_o_valid", {31'h0, o_valid}, 32'h0);
    endtask

    initial begin
        int fd0, ov0, n, has_tx, t;
        logic [W-1:0] dummy;

        rst = 1'b1; sclk = 1'b0; csb = 1'b1; mosi = 1'b0; o_ready = 1'b0;
        wait_clk(3);
        check("rst_i_ready", {31'h0, i_ready}, 32'h1);
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h0);
        rst = 1'b0;
        wait_clk(10);

        // Single-word frames with a preloaded tx word.
        vecs[0] = '{tx: 8'h3C, rx: 8'hA5, exp_miso: 8'h3C, exp_odata: 8'hA5};
        vecs[1] = '{tx: 8'hFF, rx: 8'h00, exp_miso: 8'hFF, exp_odata: 8'h00};
        vecs[2] = '{tx: 8'h81, rx: 8'h7E, exp_miso: 8'h81, exp_odata: 8'h7E};
        vecs[3] = '{tx: 8'h00, rx: 8'hFF, exp_miso: 8'h00, exp_odata: 8'hFF};
        vecs[4] = '{tx: 8'h5A, rx: 8'hC3, exp_miso: 8'h5A, exp_odata: 8'hC3};
        for (int v = 0; v < 5; v++) begin
            preload(vecs[v].tx);
            fr_mosi[0] = vecs[v].rx;
            fd0 = fd_cnt;
            run_frame(1);
            check("vec_miso", {24'h0, fr_miso[0]}, {24'h0, vecs[v].exp_miso});
            check("vec_o_valid", {31'h0, o_valid}, 32'h1);
            check("vec_o_data", {24'h0, o_data}, {24'h0, vecs[v].exp_odata});
            check("vec_frame_done", fd_cnt - fd0, 1);
            check("vec_bit_counter", {28'h0, bit_counter}, 32'h0);
            drain();
        end
        check("vec_underrun", {31'h0, underrun}, 32'h0);
        check("vec_overrun", {31'h0, overrun}, 32'h0);
        check("vec_mode_err", {31'h0, mode_err}, 32'h0);

        // Three-word frame with nothing to send.
        mon_en = 1'b1; o_ready = 1'b1;
        fr_mosi[0] = 8'h12; fr_mosi[1] = 8'h34; fr_mosi[2] = 8'h56;
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        ov0 = ov_cnt;
        run_frame(3);
        for (int k = 0; k < 3; k++) check("multi_miso", {24'h0, fr_miso[k]}, 32'h0);
        check("multi_all_words", exp_q.size(), 0);
        check("multi_o_valid_pulses", ov_cnt - ov0, 3);
        check("multi_underrun", {31'h0, underrun}, 32'h1);

        // Randomized frames: the controller must see the supplied words (or
        // zeros when none are supplied) and the consumer every mosi word.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 4);
            has_tx = $urandom_range(0, 1);
            for (int k = 0; k < n; k++) begin
                fr_mosi[k] = W'($urandom);
                fr_txw[k]  = has_tx != 0 ? W'($urandom) : '0;
                exp_q.push_back(fr_mosi[k]);
                if (has_tx != 0) tx_q.push_back(fr_txw[k]);
            end
            t = 0;
            while (has_tx != 0 && i_ready && t < 20) begin
                wait_clk(1);
                t++;
            end
            if (has_tx != 0) check("rand_preload", {31'h0, i_ready}, 32'h0);
            fd0 = fd_cnt;
            run_frame(n);
            for (int k = 0; k < n; k++) check("rand_miso", {24'h0, fr_miso[k]}, {24'h0, fr_txw[k]});
            check("rand_all_words", exp_q.size(), 0);
            check("rand_frame_done", fd_cnt - fd0, 1);
        end

        // Overrun: consumer never ready across two words.
        mon_en = 1'b0; o_ready = 1'b0;
        fr_mosi[0] = 8'hAA; fr_mosi[1] = 8'h55;
        run_frame(2);
        check("ovr_overrun", {31'h0, overrun}, 32'h1);
        check("ovr_o_data", {24'h0, o_data}, 32'h55);
        check("ovr_o_valid", {31'h0, o_valid}, 32'h1);

        // Asynchronous reset between clock edges with the holding register full.
        preload(8'h99);
        #2;
        rst = 1'b1;
        #1;
        check("arst_i_ready", {31'h0, i_ready}, 32'h1);
        check("arst_o_valid", {31'h0, o_valid}, 32'h0);
        check("arst_o_data", {24'h0, o_data}, 32'h0);
        check("arst_flags", {29'h0, underrun, overrun, mode_err}, 32'h0);
        check("arst_miso_fd", {30'h0, miso, frame_done}, 32'h0);
        check("arst_bit_counter", {28'h0, bit_counter}, 32'h0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);

        // Frame aborted after five bits.
        mon_en = 1'b1; o_ready = 1'b1;
        ov0 = ov_cnt; fd0 = fd_cnt;
        csb = 1'b0;
        wait_clk(8);
        spi_bits(8'hF0, 5, dummy);
        wait_clk(4);
        csb = 1'b1;
        wait_clk(10);
        check("abort_no_o_valid", ov_cnt - ov0, 0);
        check("abort_frame_done", fd_cnt - fd0, 1);
        check("abort_bit_counter", {28'h0, bit_counter}, 32'h0);
        check("abort_miso", {31'h0, miso}, 32'h0);

        // Reset mid-word, then a clean frame.
        csb = 1'b0;
        wait_clk(8);
        spi_bits(8'hFF, 4, dummy);
        sclk = 1'b1;
        wait_clk(2);
        #2;
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        sclk = 1'b0;
        csb = 1'b1;
        wait_clk(10);
        check("midrst_bit_counter", {28'h0, bit_counter}, 32'h0);
        fr_mosi[0] = 8'hC3;
        exp_q.push_back(8'hC3);
        run_frame(1);
        check("midrst_all_words", exp_q.size(), 0);
        check("midrst_o_data", {24'h0, o_data}, 32'hC3);
        check("midrst_mode_err_clear", {31'h0, mode_err}, 32'h0);

        // csb falls while sclk is high.
        sclk = 1'b1;
        wait_clk(HALF);
        csb = 1'b0;
        wait_clk(8);
        check("mode_err_set", {31'h0, mode_err}, 32'h1);
        csb = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
        wait_clk(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
